// File: rtl/dso_pkg.sv
// Shared constants and capture-state encoding for the trigger capture path.
package dso_pkg;

    localparam int DATA_W       = 12;
    localparam int DEPTH        = 640;
    localparam int ADDR_W       = 10;
    localparam int PRE_TRIG_DEF = 320;

    localparam logic [1:0] ST_PRE   = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_POST  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: synchronous write, registered read, no reset so it maps to block RAM.
module capture_ram
    import dso_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/trigger_capture.sv
// Level-crossing capture buffer: records DEPTH samples around a trigger and holds them for display.
// Optional forced trigger after a timeout in ARMED is enabled by defining AUTO_TRIG_EN.
module trigger_capture
    import dso_pkg::*;
#(
    parameter int PRE_TRIG = PRE_TRIG_DEF
`ifdef AUTO_TRIG_EN
    ,
    parameter int AUTO_TIMEOUT = 65535
`endif
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              rearm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              triggered,
    output logic              capture_done,
    output logic              auto_trig,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W  = 17;
    localparam int POST_N = DEPTH - PRE_TRIG - 1;
    localparam logic [ADDR_W:0] LIM = (ADDR_W + 1)'(DEPTH);

    // sample_valid is a strobe with no back-pressure: a sample offered outside HOLD is always taken.
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_trig_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_prev;
    logic              r_prev_valid;
    logic              r_triggered;
    logic              r_done;
    logic              r_rd_zero;
    logic              r_auto;

    logic              w_accept;
    logic              w_cross;
    logic              w_timeout;
    logic              w_fire;
    logic              w_rd_oob;
    logic [ADDR_W:0]   w_base_raw;
    logic [ADDR_W:0]   w_base;
    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W-1:0] w_phys;
    logic [DATA_W-1:0] w_ram_q;

    assign w_accept = sample_valid && (r_state != ST_HOLD);

    always_comb begin
        w_cross = 1'b0;
        if (r_prev_valid) begin
            if (trig_rising) begin
                w_cross = (r_prev < trig_level) && (trig_level <= sample_in);
            end else begin
                w_cross = (r_prev > trig_level) && (trig_level >= sample_in);
            end
        end
    end

`ifdef AUTO_TRIG_EN
    assign w_timeout = (r_cnt == CNT_W'(AUTO_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_fire = (r_state == ST_ARMED) && w_accept && (w_cross || w_timeout);

    // Logical column -> physical slot, rotated so logical PRE_TRIG lands on the trigger sample.
    assign w_rd_oob   = ({1'b0, rd_addr} >= LIM);
    assign w_base_raw = {1'b0, r_trig_ptr} + (ADDR_W + 1)'(DEPTH - PRE_TRIG);
    assign w_base     = (w_base_raw >= LIM) ? (w_base_raw - LIM) : w_base_raw;
    assign w_sum      = w_base + {1'b0, rd_addr};

    always_comb begin
        w_phys = '0;
        if (!w_rd_oob) begin
            w_phys = (w_sum >= LIM) ? ADDR_W'(w_sum - LIM) : ADDR_W'(w_sum);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_PRE;
            r_wr_ptr     <= '0;
            r_trig_ptr   <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_triggered  <= 1'b0;
            r_done       <= 1'b0;
            r_auto       <= 1'b0;
            r_rd_zero    <= 1'b1;
        end else begin
            r_rd_zero <= w_rd_oob;

            case (r_state)
                ST_PRE: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(PRE_TRIG - 1)) begin
                            r_state <= ST_ARMED;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_fire) begin
                        r_trig_ptr  <= r_wr_ptr;
                        r_triggered <= 1'b1;
                        r_cnt       <= '0;
                        r_auto      <= !w_cross;
                        if (POST_N == 0) begin
                            r_state <= ST_HOLD;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                        end
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_POST: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(POST_N - 1)) begin
                            r_state <= ST_HOLD;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (rearm) begin
                        r_state      <= ST_PRE;
                        r_cnt        <= '0;
                        r_prev_valid <= 1'b0;
                        r_triggered  <= 1'b0;
                        r_done       <= 1'b0;
                        r_auto       <= 1'b0;
                    end
                end
            endcase

            if (w_accept) begin
                r_wr_ptr     <= ptr_inc(r_wr_ptr);
                r_prev       <= sample_in;
                r_prev_valid <= 1'b1;
            end
        end
    end

    capture_ram u_ram (
        .clk     (clk),
        .i_we    (w_accept),
        .i_waddr (r_wr_ptr),
        .i_wdata (sample_in),
        .i_raddr (w_phys),
        .o_rdata (w_ram_q)
    );

    // The RAM output is not resettable, so a registered mask forces zero after reset and for out-of-range columns.
    assign rd_data      = r_rd_zero ? '0 : w_ram_q;
    assign triggered    = r_triggered;
    assign capture_done = r_done;
    assign dbg_state    = r_state;

`ifdef AUTO_TRIG_EN
    assign auto_trig = r_auto;
`else
    assign auto_trig = 1'b0;
    logic w_unused_auto;
    assign w_unused_auto = r_auto;
`endif

endmodule

// File: tb/tb_trigger_capture.sv
// Directed self-checking bench for trigger_capture; covers the AUTO_TRIG_EN build when that macro is defined.
module tb_trigger_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] trig_level;
  logic        trig_rising;
  logic        rearm;
  logic [9:0]  rd_addr;
  logic [11:0] rd_data;
  logic        triggered;
  logic        capture_done;
  logic        auto_trig;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  trigger_capture #(
    .PRE_TRIG     (320)
`ifdef AUTO_TRIG_EN
    ,
    .AUTO_TIMEOUT (1000)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .rearm        (rearm),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .triggered    (triggered),
    .capture_done (capture_done),
    .auto_trig    (auto_trig),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // drivers
  task automatic send(input logic [11:0] v, input int gap);
    @(posedge clk); #1;
    sample_in    = v;
    sample_valid = 1'b1;
    @(posedge clk); #1;
    sample_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_n(input logic [11:0] v, input int n);
    for (int k = 0; k < n; k++) send(v, 0);
  endtask

  task automatic pulse_rearm(input logic with_sample, input logic [11:0] v);
    @(posedge clk); #1;
    rearm        = 1'b1;
    sample_valid = with_sample;
    sample_in    = v;
    @(posedge clk); #1;
    rearm        = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic read_col(input int a, output logic [11:0] d);
    @(posedge clk); #1;
    rd_addr = a[9:0];
    @(posedge clk); #1;
    d = rd_data;
  endtask

  logic [11:0] d;
  int          n;

  initial begin
    reset_n      = 1'b0;
    sample_in    = '0;
    sample_valid = 1'b0;
    trig_level   = 12'd2048;
    trig_rising  = 1'b1;
    rearm        = 1'b0;
    rd_addr      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_data", rd_data, 0);
    check("rst_triggered", triggered, 0);
    check("rst_done", capture_done, 0);
    check("rst_auto", auto_trig, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: rising ramp, one sample per 4 clocks
    n = 0;
    while (!capture_done && n < 3000) begin
      send(n[11:0], 2);
      if (n == 318) check("t1_still_pre", dbg_state, 0);
      if (n == 319) check("t1_armed", dbg_state, 1);
      if (n == 2047) check("t1_not_trig", triggered, 0);
      if (n == 2048) check("t1_trig", triggered, 1);
      n++;
    end
    check("t1_count", n, 2368);
    check("t1_hold", dbg_state, 3);
    check("t1_auto", auto_trig, 0);
    read_col(320, d); check("t1_rd320", d, 2048);
    read_col(0, d);   check("t1_rd0", d, 1728);
    read_col(639, d); check("t1_rd639", d, 2367);
    // 6a: out-of-range column, and samples ignored in HOLD
    read_col(700, d); check("t6_rd700", d, 0);
    send(12'd4095, 0);
    read_col(639, d); check("t1_frozen", d, 2367);

    // 4 + 2: rearm with a coincident sample, then falling trigger
    pulse_rearm(1'b1, 12'd3000);
    check("t4_rearm_state", dbg_state, 0);
    check("t4_rearm_trig", triggered, 0);
    check("t4_rearm_done", capture_done, 0);
    trig_rising = 1'b0;
    send_n(12'd3000, 319);
    check("t4_pre_319", dbg_state, 0);
    send_n(12'd3000, 1);
    check("t4_armed_320", dbg_state, 1);
    send_n(12'd3000, 30);
    pulse_rearm(1'b0, 12'd0);
    check("t4_rearm_armed", dbg_state, 1);
    send_n(12'd3000, 50);
    send(12'd1000, 0);
    check("t2_trig", triggered, 1);
    check("t2_post", dbg_state, 2);
    pulse_rearm(1'b0, 12'd0);
    check("t4_rearm_post", dbg_state, 2);
    check("t4_rearm_post_trig", triggered, 1);
    send_n(12'd1000, 318);
    check("t2_not_done", capture_done, 0);
    send_n(12'd1000, 1);
    check("t2_done", capture_done, 1);
    read_col(319, d); check("t2_rd319", d, 3000);
    read_col(320, d); check("t2_rd320", d, 1000);
    read_col(0, d);   check("t2_rd0", d, 3000);
    read_col(639, d); check("t2_rd639", d, 1000);

    // 6b: sample equal to level never counts as the prior side of a crossing
    pulse_rearm(1'b0, 12'd0);
    send_n(12'd2048, 320);
    check("t6_armed", dbg_state, 1);
    trig_rising = 1'b0;
    send(12'd2048, 0);
    send(12'd2000, 0);
    send(12'd2048, 0);
    check("t6_no_fall", triggered, 0);
    trig_rising = 1'b1;
    send(12'd2100, 0);
    check("t6_no_rise", triggered, 0);
    check("t6_still_armed", dbg_state, 1);

    // 3: constant input below level
`ifdef AUTO_TRIG_EN
    send_n(12'd100, 995);
    check("t3_before_auto", triggered, 0);
    send_n(12'd100, 1);
    check("t3_auto_trig", triggered, 1);
    check("t3_auto_flag", auto_trig, 1);
    send_n(12'd100, 318);
    check("t3_auto_not_done", capture_done, 0);
    send_n(12'd100, 1);
    check("t3_auto_done", capture_done, 1);
    pulse_rearm(1'b0, 12'd0);
    check("t3_auto_cleared", auto_trig, 0);
    send_n(12'd100, 320);
`else
    send_n(12'd100, 10000);
    check("t3_no_done", capture_done, 0);
    check("t3_no_trig", triggered, 0);
    check("t3_auto_zero", auto_trig, 0);
    check("t3_armed", dbg_state, 1);
`endif
    send(12'd3000, 0);
    check("t5_trig", triggered, 1);
    check("t5_auto_real", auto_trig, 0);

    // 5: asynchronous reset in the middle of POST
    send_n(12'd3000, 10);
    check("t5_in_post", dbg_state, 2);
    rd_addr = 10'd320;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("t5_async_trig", triggered, 0);
    check("t5_async_done", capture_done, 0);
    check("t5_async_rd", rd_data, 0);
    check("t5_async_state", dbg_state, 0);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!capture_done && n < 1000) begin
      send(12'(1700 + n), 0);
      n++;
    end
    check("t5_count", n, 668);
    read_col(320, d); check("t5_rd320", d, 2048);
    read_col(0, d);   check("t5_rd0", d, 1728);
    read_col(639, d); check("t5_rd639", d, 2367);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
